ccip_mmio_responder: RTL and testbench
======================================

// Module: ccip_mmio_responder
// PURPOSE
// AFU-side MMIO target for CCI-P: consumes MMIO read/write requests on C0Rx and returns
// MMIO read responses on C2Tx with the matching tid. Holds the DFH, AFU ID, scratch and
// status CSRs. Answers the MMIORdReq/MMIORdRsp traffic the transaction logger records.
// PARAMETERS
// DFH_VALUE    64'h1000_0000_0000_0000  RO value at 0x000 (DFH)
// AFU_ID_L     64'h0                    RO value at 0x008
// AFU_ID_H     64'h0                    RO value at 0x010
// NUM_SCRATCH  4                        64b RW scratch regs at 0x028 + 8*i (1..16)
// RD_LATENCY   2                        request-to-C2 response latency in cycles (1..8)
// PORTS
// clk            in   1      interface clock
// SoftReset_n    in   1      async active-low reset
// ccip_rx        in   t_if_ccip_Rx     only c0.mmioRdValid/mmioWrValid/hdr/data used
// ccip_c2_tx     out  t_if_ccip_c2_Tx  mmioRdValid, hdr.tid, data[63:0]
// scratch0       out  64     live value of scratch[0] for AFU logic
// err_flags      out  4      sticky STATUS[3:0], mirrored
// BEHAVIOUR
// - Header = t_ccip_c0_ReqMmioHdr: address in 4B units, length 00=4B 01=8B 10=64B 11=rsvd, tid 9b.
// - Map (byte offset; qword = address[15:1]): 0x000 DFH, 0x008 AFU_ID_L, 0x010 AFU_ID_H,
//   0x018/0x020 RO zero, scratch[i], then STATUS at 0x028+8*NUM_SCRATCH, COUNT at next qword.
// - STATUS[0] PROTO_ERR rd+wr same cycle; [1] LEN_ERR length 10/11; [2] ALIGN_ERR 8B with
//   address[0]=1; [3] UNMAPPED. Sticky; write-1-to-clear on STATUS write (8B or low-dword 4B).
// - COUNT: [31:0] MMIO reads accepted, [63:32] MMIO writes accepted; RO; wrap at 2^32.
// - Write (mmioWrValid): 8B writes data[63:0]; 4B writes data[31:0] into dword address[0].
//   Commits at the clock edge ending the request cycle; RO/unmapped targets ignored.
// - Read (mmioRdValid): value sampled from state at request cycle N (a write in N-1 is visible);
//   4B returns selected dword in [31:0], [63:32]=0. ccip_c2_tx.mmioRdValid pulses exactly at
//   N+RD_LATENCY with same tid. Pipeline accepts one read every cycle; no backpressure (C2 has
//   none); back-to-back reads return back-to-back, in order.
// - Error reads (LEN/ALIGN/UNMAPPED) still respond, data=0, set flag. Writes with errors are
//   dropped, flag set.
// - rd+wr same cycle: write performed, read dropped (no response), PROTO_ERR set, counters
//   count write only.
// - Errors raised same cycle as W1C of that bit: set wins.
// - Reset (async assert, sync deassert handled upstream): all scratch=0, STATUS=0, COUNT=0,
//   pipeline flushed; ccip_c2_tx all zero; scratch0=0; err_flags=0. Reads in flight when
//   reset asserts are lost, no response after release.
// STRUCTURE
// - ccip_if_pkg: existing t_if_ccip_Rx, t_if_ccip_c2_Tx, t_ccip_c0_ReqMmioHdr, t_ccip_mmioAddr.
// - ase_pkg additions: MMIO_LEN_4B/8B/64B constants, t_mmio_status bit struct, CSR offset
//   localparams shared with SW-side tests.
// - Sub-module ccip_mmio_rsp_pipe: RD_LATENCY-deep shift register of {valid,tid,data}, async
//   reset of valid bits only; top holds decode, CSR file, counters, error logic.
// TESTING
// - Reset then 8B read 0x000 tid=0x05 -> RD_LATENCY cycles later mmioRdValid=1, tid=0x05,
//   data=DFH_VALUE; no other response pulses.
// - 8B write 0x028 data=64'hDEAD_BEEF_CAFE_F00D, next cycle 4B read address=0x00B tid=0x1FF ->
//   data=64'h0000_0000_DEAD_BEEF, tid=0x1FF; scratch0 reflects write.
// - 16 back-to-back reads tid 0..15 -> 16 consecutive responses, in order, tids 0..15;
//   COUNT[31:0]=16.
// - 64B read 0x000 -> data=0, STATUS=4'b0010; 8B read address=0x001 -> data=0, STATUS=4'b0110;
//   write STATUS=4'hF -> STATUS=0.
// - rd+wr same cycle to scratch[1] -> write lands, no C2 response, STATUS[0]=1, COUNT={1,0}.
// - Read issued, SoftReset_n low one cycle before response -> no response; all CSRs 0.

Source files
------------

// File: rtl/ccip_mmio_responder_pkg.sv
// ccip_mmio_responder_pkg
// Shared types and constants for the CCI-P MMIO responder: the reduced CCI-P
// channel structs the responder consumes/produces, MMIO length encodings, the
// STATUS bit layout and the qword offsets of the CSR map (shared with SW tests).
package ccip_mmio_responder_pkg;

    localparam int unsigned CCIP_TID_W  = 9;
    localparam int unsigned CCIP_DATA_W = 64;

    typedef logic [15:0] t_ccip_mmioAddr;   // 4-byte units
    typedef logic [1:0]  t_mmio_len;

    localparam t_mmio_len MMIO_LEN_4B   = 2'b00;
    localparam t_mmio_len MMIO_LEN_8B   = 2'b01;
    localparam t_mmio_len MMIO_LEN_64B  = 2'b10;
    localparam t_mmio_len MMIO_LEN_RSVD = 2'b11;

    typedef struct packed {
        t_ccip_mmioAddr          address;
        t_mmio_len               length;
        logic [CCIP_TID_W-1:0]   tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr     hdr;
        logic [CCIP_DATA_W-1:0]  data;
        logic                    mmioRdValid;
        logic                    mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_if_ccip_c0_Rx c0;
    } t_if_ccip_Rx;

    typedef struct packed {
        logic [CCIP_TID_W-1:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr     hdr;
        logic                    mmioRdValid;
        logic [CCIP_DATA_W-1:0]  data;
    } t_if_ccip_c2_Tx;

    // STATUS[3:0], bit 0 is proto_err.
    typedef struct packed {
        logic unmapped;
        logic align_err;
        logic len_err;
        logic proto_err;
    } t_mmio_status;

    // CSR map as qword indices (byte offset / 8).
    localparam int unsigned CSR_DFH_QW          = 0;
    localparam int unsigned CSR_AFU_ID_L_QW     = 1;
    localparam int unsigned CSR_AFU_ID_H_QW     = 2;
    localparam int unsigned CSR_SCRATCH_BASE_QW = 5;

    function automatic int unsigned csr_status_qw(input int unsigned num_scratch);
        return CSR_SCRATCH_BASE_QW + num_scratch;
    endfunction

    function automatic int unsigned csr_count_qw(input int unsigned num_scratch);
        return CSR_SCRATCH_BASE_QW + num_scratch + 1;
    endfunction

endpackage

// File: rtl/ccip_mmio_rsp_pipe.sv
// ccip_mmio_rsp_pipe
// Fixed-latency shift register carrying {valid, tid, data} for MMIO read
// responses. Only the valid bits are reset; tid/data are don't-care when invalid.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   in_vld_i/tid_i/data_i    response captured at the end of the request cycle
//   out_vld_o/tid_o/data_o   response DEPTH cycles after the request cycle
module ccip_mmio_rsp_pipe #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TID_W  = 9,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld_i,
    input  logic [TID_W-1:0]  in_tid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_vld_o,
    output logic [TID_W-1:0]  out_tid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DEPTH-1:0]  vld_q;
    logic [TID_W-1:0]  tid_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_vld_i;
            for (int i = 1; i < int'(DEPTH); i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        tid_q[0]  <= in_tid_i;
        data_q[0] <= in_data_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            tid_q[i]  <= tid_q[i-1];
            data_q[i] <= data_q[i-1];
        end
    end

    assign out_vld_o  = vld_q[DEPTH-1];
    assign out_tid_o  = tid_q[DEPTH-1];
    assign out_data_o = data_q[DEPTH-1];

endmodule

// File: rtl/ccip_mmio_responder.sv
// ccip_mmio_responder
// AFU-side CCI-P MMIO target: decodes MMIO reads/writes from C0Rx, holds the
// DFH / AFU ID / scratch / STATUS / COUNT CSRs and returns read responses on
// C2Tx a fixed RD_LATENCY cycles after the request with the request's tid.
// Ports:
//   clk          interface clock
//   SoftReset_n  async active-low reset
//   ccip_rx      C0 MMIO request channel (mmioRdValid/mmioWrValid/hdr/data)
//   ccip_c2_tx   MMIO read response channel (mmioRdValid, tid, data)
//   scratch0     live value of scratch[0]
//   err_flags    sticky STATUS[3:0]
module ccip_mmio_responder
    import ccip_mmio_responder_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0,
    parameter int unsigned NUM_SCRATCH = 4,
    parameter int unsigned RD_LATENCY  = 2
) (
    input  logic           clk,
    input  logic           SoftReset_n,
    input  t_if_ccip_Rx    ccip_rx,
    output t_if_ccip_c2_Tx ccip_c2_tx,
    output logic [63:0]    scratch0,
    output logic [3:0]     err_flags
);

    localparam logic [14:0] QW_STATUS = 15'(csr_status_qw(NUM_SCRATCH));
    localparam logic [14:0] QW_COUNT  = 15'(csr_count_qw(NUM_SCRATCH));

    t_ccip_c0_ReqMmioHdr hdr;
    logic                rd_vld, wr_vld;
    logic [14:0]         qw;
    logic                dsel;
    logic                len_err, align_err, unmapped, req_err;
    logic                rd_fire, wr_ok;
    logic [63:0]         qword_val, rd_data, wr_data;

    logic [63:0]  scratch_q [NUM_SCRATCH];
    logic [63:0]  scratch_d [NUM_SCRATCH];
    t_mmio_status status_q, status_d;
    logic [31:0]  rd_cnt_q, rd_cnt_d;
    logic [31:0]  wr_cnt_q, wr_cnt_d;

    logic                  rsp_vld;
    logic [CCIP_TID_W-1:0] rsp_tid;
    logic [63:0]           rsp_data;

    assign hdr     = ccip_rx.c0.hdr;
    assign rd_vld  = ccip_rx.c0.mmioRdValid;
    assign wr_vld  = ccip_rx.c0.mmioWrValid;
    assign wr_data = ccip_rx.c0.data;
    assign qw      = hdr.address[15:1];
    assign dsel    = hdr.address[0];

    assign len_err   = (hdr.length == MMIO_LEN_64B) || (hdr.length == MMIO_LEN_RSVD);
    assign align_err = (hdr.length == MMIO_LEN_8B) && hdr.address[0];
    assign unmapped  = (qw > QW_COUNT);
    assign req_err   = len_err || align_err || unmapped;

    // A read colliding with a write is dropped; the write still goes ahead.
    assign rd_fire = rd_vld && !wr_vld;
    assign wr_ok   = wr_vld && !req_err;

    always_comb begin
        qword_val = '0;
        if (qw == 15'(CSR_DFH_QW))      qword_val = DFH_VALUE;
        if (qw == 15'(CSR_AFU_ID_L_QW)) qword_val = AFU_ID_L;
        if (qw == 15'(CSR_AFU_ID_H_QW)) qword_val = AFU_ID_H;
        for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            if (qw == 15'(CSR_SCRATCH_BASE_QW + i)) qword_val = scratch_q[i];
        end
        if (qw == QW_STATUS) qword_val = {60'd0, status_q};
        if (qw == QW_COUNT)  qword_val = {wr_cnt_q, rd_cnt_q};
    end

    always_comb begin
        if (req_err) begin
            rd_data = '0;
        end else if (hdr.length == MMIO_LEN_4B) begin
            rd_data = {32'd0, (dsel ? qword_val[63:32] : qword_val[31:0])};
        end else begin
            rd_data = qword_val;
        end
    end

    always_comb begin
        scratch_d = scratch_q;
        for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            if (wr_ok && (qw == 15'(CSR_SCRATCH_BASE_QW + i))) begin
                if (hdr.length == MMIO_LEN_8B) begin
                    scratch_d[i] = wr_data;
                end else if (dsel) begin
                    scratch_d[i][63:32] = wr_data[31:0];
                end else begin
                    scratch_d[i][31:0] = wr_data[31:0];
                end
            end
        end
    end

    // W1C first, then OR in this cycle's errors so a new error beats its own clear.
    always_comb begin
        status_d = status_q;
        if (wr_ok && (qw == QW_STATUS) && ((hdr.length == MMIO_LEN_8B) || !dsel)) begin
            status_d = status_q & ~t_mmio_status'(wr_data[3:0]);
        end
        if (rd_vld && wr_vld)                  status_d.proto_err = 1'b1;
        if ((rd_vld || wr_vld) && len_err)     status_d.len_err   = 1'b1;
        if ((rd_vld || wr_vld) && align_err)   status_d.align_err = 1'b1;
        if ((rd_vld || wr_vld) && unmapped)    status_d.unmapped  = 1'b1;
    end

    assign rd_cnt_d = rd_cnt_q + {31'd0, rd_fire};
    assign wr_cnt_d = wr_cnt_q + {31'd0, wr_vld};

    always_ff @(posedge clk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
                scratch_q[i] <= '0;
            end
            status_q <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            scratch_q <= scratch_d;
            status_q  <= status_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    ccip_mmio_rsp_pipe #(
        .DEPTH  (RD_LATENCY),
        .TID_W  (CCIP_TID_W),
        .DATA_W (64)
    ) u_rsp_pipe (
        .clk        (clk),
        .rst_n      (SoftReset_n),
        .in_vld_i   (rd_fire),
        .in_tid_i   (hdr.tid),
        .in_data_i  (rd_data),
        .out_vld_o  (rsp_vld),
        .out_tid_o  (rsp_tid),
        .out_data_o (rsp_data)
    );

    // Pipe payload is unreset, so mask it to keep C2 all-zero when idle.
    always_comb begin
        ccip_c2_tx             = '0;
        ccip_c2_tx.mmioRdValid = rsp_vld;
        if (rsp_vld) begin
            ccip_c2_tx.hdr.tid = rsp_tid;
            ccip_c2_tx.data    = rsp_data;
        end
    end

    assign scratch0  = scratch_q[0];
    assign err_flags = status_q;

endmodule

// File: tb/tb_ccip_mmio_responder.sv
module tb_ccip_mmio_responder;
    import ccip_mmio_responder_pkg::*;

    localparam int unsigned LAT = 2;
    localparam logic [63:0] DFH = 64'h1000_0000_0000_0000;

    // 4B-unit addresses for the default map (NUM_SCRATCH=4)
    localparam logic [15:0] A_DFH    = 16'h000;
    localparam logic [15:0] A_AFUL   = 16'h002;
    localparam logic [15:0] A_RSVD   = 16'h006;
    localparam logic [15:0] A_SCR0   = 16'h00A;
    localparam logic [15:0] A_SCR1   = 16'h00C;
    localparam logic [15:0] A_SCR2   = 16'h00E;
    localparam logic [15:0] A_STATUS = 16'h012;
    localparam logic [15:0] A_COUNT  = 16'h014;
    localparam logic [15:0] A_UNMAP  = 16'h016;

    logic           clk;
    logic           SoftReset_n;
    t_if_ccip_Rx    rx;
    t_if_ccip_c2_Tx c2;
    logic [63:0]    scratch0;
    logic [3:0]     err_flags;

    int checks;
    int failures;
    int cyc;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    ccip_mmio_responder dut (
        .clk         (clk),
        .SoftReset_n (SoftReset_n),
        .ccip_rx     (rx),
        .ccip_c2_tx  (c2),
        .scratch0    (scratch0),
        .err_flags   (err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Response scoreboard: every C2 pulse must match the oldest expectation at its due cycle.
    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (c2.mmioRdValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp cyc=%0d got tid=%h data=%h required no response",
                             cyc, c2.hdr.tid, c2.data);
                end else begin
                    e = exp_q.pop_front();
                    if (c2.hdr.tid !== e.tid || c2.data !== e.data || cyc != e.due) begin
                        failures++;
                        $display("FAIL rsp cyc=%0d got tid=%h data=%h required tid=%h data=%h at cyc=%0d",
                                 cyc, c2.hdr.tid, c2.data, e.tid, e.data, e.due);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                checks++;
                failures++;
                e = exp_q.pop_front();
                $display("FAIL missing_rsp cyc=%0d got none required tid=%h data=%h", cyc, e.tid, e.data);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit rd, input bit wr, input logic [15:0] addr,
                             input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
        rx.c0.hdr.address  = addr;
        rx.c0.hdr.length   = len;
        rx.c0.hdr.tid      = tid;
        rx.c0.data         = data;
        rx.c0.mmioRdValid  = rd;
        rx.c0.mmioWrValid  = wr;
        @(posedge clk);
        #1;
        rx.c0.mmioRdValid  = 1'b0;
        rx.c0.mmioWrValid  = 1'b0;
    endtask

    task automatic rd_req(input logic [15:0] addr, input logic [1:0] len,
                          input logic [8:0] tid, input logic [63:0] exp_data);
        exp_t e;
        e.tid  = tid;
        e.data = exp_data;
        e.due  = cyc + int'(LAT);
        exp_q.push_back(e);
        drive_req(1'b1, 1'b0, addr, len, tid, 64'd0);
    endtask

    task automatic wr_req(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
        drive_req(1'b0, 1'b1, addr, len, 9'd0, data);
    endtask

    task automatic do_reset();
        idle(LAT + 2);
        SoftReset_n = 1'b0;
        idle(2);
        SoftReset_n = 1'b1;
        idle(1);
    endtask

    task automatic test_reset();
        SoftReset_n = 1'b1;
        rx = '0;
        #3 SoftReset_n = 1'b0;
        idle(2);
        checks++;
        if (c2 !== '0 || scratch0 !== 64'd0 || err_flags !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs got c2=%h scratch0=%h err=%h required all zero",
                     c2, scratch0, err_flags);
        end
        SoftReset_n = 1'b1;
        idle(1);
        rd_req(A_COUNT, MMIO_LEN_8B, 9'h001, 64'd0);
        rd_req(A_SCR2, MMIO_LEN_8B, 9'h002, 64'd0);
        idle(LAT + 1);
    endtask

    task automatic test_ro_read();
        rd_req(A_DFH, MMIO_LEN_8B, 9'h005, DFH);
        idle(LAT + 2);
        rd_req(A_AFUL, MMIO_LEN_8B, 9'h006, 64'd0);
        rd_req(A_RSVD, MMIO_LEN_8B, 9'h007, 64'd0);
        wr_req(A_DFH, MMIO_LEN_8B, 64'h0);
        rd_req(A_DFH, MMIO_LEN_8B, 9'h008, DFH);
        idle(LAT + 1);
    endtask

    task automatic test_scratch();
        wr_req(A_SCR0, MMIO_LEN_8B, 64'hDEAD_BEEF_CAFE_F00D);
        rd_req(A_SCR0 + 16'd1, MMIO_LEN_4B, 9'h1FF, 64'h0000_0000_DEAD_BEEF);
        checks++;
        if (scratch0 !== 64'hDEAD_BEEF_CAFE_F00D) begin
            failures++;
            $display("FAIL scratch0_8b got %h required %h", scratch0, 64'hDEAD_BEEF_CAFE_F00D);
        end
        rd_req(A_SCR0, MMIO_LEN_4B, 9'h010, 64'h0000_0000_CAFE_F00D);
        wr_req(A_SCR2 + 16'd1, MMIO_LEN_4B, 64'hFFFF_FFFF_1234_5678);
        rd_req(A_SCR2, MMIO_LEN_8B, 9'h011, 64'h1234_5678_0000_0000);
        wr_req(A_SCR0, MMIO_LEN_4B, 64'h0000_0000_0BAD_CAFE);
        checks++;
        if (scratch0 !== 64'hDEAD_BEEF_0BAD_CAFE) begin
            failures++;
            $display("FAIL scratch0_4b got %h required %h", scratch0, 64'hDEAD_BEEF_0BAD_CAFE);
        end
        idle(LAT + 1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rd_req(A_DFH, MMIO_LEN_8B, 9'(i), DFH);
        end
        rd_req(A_COUNT, MMIO_LEN_8B, 9'h040, 64'h0000_0000_0000_0010);
        idle(LAT + 1);
    endtask

    task automatic check_err(input string name, input logic [3:0] exp);
        checks++;
        if (err_flags !== exp) begin
            failures++;
            $display("FAIL %s got err_flags=%b required %b", name, err_flags, exp);
        end
    endtask

    task automatic test_errors();
        do_reset();
        rd_req(A_DFH, MMIO_LEN_64B, 9'h020, 64'd0);
        check_err("len_err", 4'b0010);
        rd_req(16'h001, MMIO_LEN_8B, 9'h021, 64'd0);
        check_err("align_err", 4'b0110);
        rd_req(A_UNMAP, MMIO_LEN_8B, 9'h022, 64'd0);
        check_err("unmapped", 4'b1110);
        rd_req(16'h001, MMIO_LEN_4B, 9'h023, 64'h0000_0000_1000_0000);
        check_err("4b_odd_ok", 4'b1110);
        wr_req(A_STATUS + 16'd1, MMIO_LEN_4B, 64'hF);
        check_err("w1c_hi_dword_ignored", 4'b1110);
        wr_req(A_STATUS, MMIO_LEN_8B, 64'hF);
        check_err("w1c_8b", 4'b0000);
        wr_req(A_SCR0 + 16'd1, MMIO_LEN_8B, 64'hFFFF_FFFF_FFFF_FFFF);
        check_err("wr_align_err", 4'b0100);
        checks++;
        if (scratch0 !== 64'd0) begin
            failures++;
            $display("FAIL err_wr_dropped got scratch0=%h required 0", scratch0);
        end
        drive_req(1'b1, 1'b1, A_STATUS, MMIO_LEN_8B, 9'h024, 64'hF);
        check_err("set_wins_over_w1c", 4'b0001);
        wr_req(A_STATUS, MMIO_LEN_4B, 64'h1);
        check_err("w1c_4b_lo", 4'b0000);
        idle(LAT + 1);
    endtask

    task automatic test_collision();
        do_reset();
        drive_req(1'b1, 1'b1, A_SCR1, MMIO_LEN_8B, 9'h033, 64'h1111_2222_3333_4444);
        check_err("proto_err", 4'b0001);
        rd_req(A_COUNT, MMIO_LEN_8B, 9'h034, 64'h0000_0001_0000_0000);
        rd_req(A_SCR1, MMIO_LEN_8B, 9'h035, 64'h1111_2222_3333_4444);
        idle(LAT + 1);
    endtask

    task automatic test_reset_inflight();
        wr_req(A_SCR0, MMIO_LEN_8B, 64'h5555_6666_7777_8888);
        rd_req(A_UNMAP, MMIO_LEN_8B, 9'h050, 64'd0);
        idle(LAT + 1);
        // This read must be lost: it is not pushed to the scoreboard.
        drive_req(1'b1, 1'b0, A_DFH, MMIO_LEN_8B, 9'h007, 64'd0);
        SoftReset_n = 1'b0;
        #1;
        checks++;
        if (c2 !== '0) begin
            failures++;
            $display("FAIL inflight_reset_c2 got %h required 0", c2);
        end
        idle(1);
        SoftReset_n = 1'b1;
        idle(4);
        checks++;
        if (scratch0 !== 64'd0 || err_flags !== 4'd0) begin
            failures++;
            $display("FAIL inflight_reset_csr got scratch0=%h err=%h required 0/0", scratch0, err_flags);
        end
        rd_req(A_COUNT, MMIO_LEN_8B, 9'h051, 64'd0);
        idle(LAT + 1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rx       = '0;
        fork
            run_monitor();
        join_none
        test_reset();
        test_ro_read();
        test_scratch();
        test_back_to_back();
        test_errors();
        test_collision();
        test_reset_inflight();
        idle(LAT + 3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
